// File: rtl/out_tile_writer.sv
// Output tile writer: takes BLOCK_SIZE x BLOCK_SIZE result tiles from the
// systolic core and writes each tile row into its lane of a CHUNK_SIZE-wide
// BRAM word on port A, using byte write enables so that neighbouring lanes
// written by other tiles are left untouched.
module out_tile_writer #(
  parameter int WIDTH             = 16,
  parameter int BLOCK_SIZE        = 2,
  parameter int CHUNK_SIZE        = 4,
  parameter int W_OUTER_DIMENSION = 8,
  parameter int I_OUTER_DIMENSION = 6,
  parameter int ADDR_WIDTH        = 12
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clr,
  input  logic                                   start,
  output logic                                   ready,
  output logic                                   done,
  input  logic                                   tile_valid,
  output logic                                   tile_ready,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] tile_data,
  output logic                                   out_ena,
  output logic [WIDTH*CHUNK_SIZE/8-1:0]          out_wea,
  output logic [ADDR_WIDTH-1:0]                  out_addra,
  output logic [WIDTH*CHUNK_SIZE-1:0]            out_dina
);

  localparam int WPR       = W_OUTER_DIMENSION / CHUNK_SIZE;
  localparam int TR        = I_OUTER_DIMENSION / BLOCK_SIZE;
  localparam int TC        = W_OUTER_DIMENSION / BLOCK_SIZE;
  localparam int MAX_FLAG  = TR * TC;
  localparam int NBE       = WIDTH * CHUNK_SIZE / 8;
  localparam int LANES     = CHUNK_SIZE / BLOCK_SIZE;
  localparam int TILE_W    = BLOCK_SIZE * BLOCK_SIZE * WIDTH;
  localparam int WORD_W    = WIDTH * CHUNK_SIZE;
  localparam int ROW_BYTES = BLOCK_SIZE * WIDTH / 8;
  localparam int TRW       = (TR > 1) ? $clog2(TR) : 1;
  localparam int TCW       = (TC > 1) ? $clog2(TC) : 1;
  localparam int ROWW      = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  // Byte enables covering one tile row, positioned at lane 0.
  localparam logic [NBE-1:0] ROW_MASK = NBE'({ROW_BYTES{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TRW-1:0]        tileRow_q, tileRow_d;
  logic [TCW-1:0]        tileCol_q, tileCol_d;
  logic [ROWW-1:0]       row_q, row_d;
  logic [TILE_W-1:0]     tile_q, tile_d;
  logic                  ready_q, done_q, tileReady_q;
  logic                  ena_q, ena_d;
  logic [NBE-1:0]        wea_q, wea_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     din_q, din_d;
  logic                  lastTile;

  assign lastTile = ((int'(tileRow_q) * TC + int'(tileCol_q)) == (MAX_FLAG - 1));

  assign ready      = ready_q;
  assign done       = done_q;
  assign tile_ready = tileReady_q;
  assign out_ena    = ena_q;
  assign out_wea    = wea_q;
  assign out_addra  = addr_q;
  assign out_dina   = din_q;

  // Next-state logic: tile handshake, row sequencing and tile position counters.
  always_comb begin
    state_d   = state_q;
    tileRow_d = tileRow_q;
    tileCol_d = tileCol_q;
    row_d     = row_q;
    tile_d    = tile_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT;
          tileRow_d = '0;
          tileCol_d = '0;
        end
      end
      WAIT: begin
        if (tile_valid && tileReady_q) begin
          state_d = WRITE;
          row_d   = '0;
          tile_d  = tile_data;
        end
      end
      WRITE: begin
        if (row_q == ROWW'(BLOCK_SIZE - 1)) begin
          if (lastTile) begin
            state_d   = DONE;
            tileRow_d = '0;
            tileCol_d = '0;
          end else begin
            state_d = WAIT;
            if (tileCol_q == TCW'(TC - 1)) begin
              tileCol_d = '0;
              tileRow_d = tileRow_q + TRW'(1);
            end else begin
              tileCol_d = tileCol_q + TCW'(1);
            end
          end
        end else begin
          row_d = row_q + ROWW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d   = IDLE;
      tileRow_d = '0;
      tileCol_d = '0;
      row_d     = '0;
    end
  end

  // Port A strobe for the upcoming cycle: row row_d of the held tile, packed into its lane.
  always_comb begin
    int trI;
    int tcI;
    int rI;
    int lane;
    logic [WIDTH-1:0] elem;
    ena_d  = 1'b0;
    wea_d  = '0;
    addr_d = '0;
    din_d  = '0;
    elem   = '0;
    trI    = int'(tileRow_q);
    tcI    = int'(tileCol_q);
    rI     = int'(row_d);
    lane   = (tcI % LANES) * BLOCK_SIZE;
    if (state_d == WRITE) begin
      ena_d  = 1'b1;
      addr_d = ADDR_WIDTH'((trI * BLOCK_SIZE + rI) * WPR + tcI / LANES);
      wea_d  = ROW_MASK << (lane * WIDTH / 8);
      for (int c = 0; c < BLOCK_SIZE; c++) begin
        elem  = WIDTH'(tile_d >> ((rI * BLOCK_SIZE + c) * WIDTH));
        din_d = din_d | (WORD_W'(elem) << ((lane + c) * WIDTH));
      end
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tileRow_q   <= '0;
      tileCol_q   <= '0;
      row_q       <= '0;
      tile_q      <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      tileReady_q <= 1'b0;
      ena_q       <= 1'b0;
      wea_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      tileRow_q   <= tileRow_d;
      tileCol_q   <= tileCol_d;
      row_q       <= row_d;
      tile_q      <= tile_d;
      ready_q     <= (state_d == IDLE);
      done_q      <= (state_d == DONE);
      tileReady_q <= (state_d == WAIT);
      ena_q       <= ena_d;
      wea_q       <= wea_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

endmodule

// File: tb/tb_out_tile_writer.sv
// Bench for out_tile_writer with default parameters (16-bit elements, 2x2
// tiles, 4-element words, 6x8 result matrix).
module tb_out_tile_writer;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        start;
  logic        ready;
  logic        done;
  logic        tile_valid;
  logic        tile_ready;
  logic [63:0] tile_data;
  logic        out_ena;
  logic [7:0]  out_wea;
  logic [11:0] out_addra;
  logic [63:0] out_dina;

  typedef struct {
    logic [63:0] data;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [7:0]  wea;
  } tileVec_t;

  tileVec_t    vecs[12];
  logic [63:0] mem[4096];
  int          checks;
  int          failures;
  int          writeCount;
  int          doneCount;

  out_tile_writer dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .start     (start),
    .ready     (ready),
    .done      (done),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .tile_data (tile_data),
    .out_ena   (out_ena),
    .out_wea   (out_wea),
    .out_addra (out_addra),
    .out_dina  (out_dina)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_ena) begin
      writeCount++;
      for (int b = 0; b < 8; b++) begin
        if (out_wea[b]) mem[int'(out_addra)][b*8 +: 8] = out_dina[b*8 +: 8];
      end
    end
    if (done) doneCount++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] expectedDin(input logic [63:0] data, input int r, input logic [7:0] wea);
    logic [31:0] half;
    half = data[r*32 +: 32];
    return (wea == 8'h0F) ? {32'h0, half} : {half, 32'h0};
  endfunction

  // Presents table tile idx, waits for acceptance and checks both row writes.
  task automatic applyStimulus(input int idx, input bit pulseStart, input bit abortFirst);
    bit ok;
    bit last;
    last       = (idx == 11);
    tile_data  = vecs[idx].data;
    tile_valid = 1'b1;
    if (pulseStart) start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (tile_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL acceptTimeout tile %0d: got tile_ready=0, expected 1", idx);
      tile_valid = 1'b0;
      start = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    tile_data = ~vecs[idx].data;
    checkOutput($sformatf("t%0d r0 ena", idx), 64'(out_ena), 64'd1);
    checkOutput($sformatf("t%0d r0 addr", idx), 64'(out_addra), 64'(vecs[idx].addr0));
    checkOutput($sformatf("t%0d r0 wea", idx), 64'(out_wea), 64'(vecs[idx].wea));
    checkOutput($sformatf("t%0d r0 din", idx), out_dina, expectedDin(vecs[idx].data, 0, vecs[idx].wea));
    checkOutput($sformatf("t%0d r0 tile_ready", idx), 64'(tile_ready), 64'd0);
    if (abortFirst) begin
      clr = 1'b1;
      tile_valid = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b0;
      checkOutput("abort ena", 64'(out_ena), 64'd0);
      checkOutput("abort wea", 64'(out_wea), 64'd0);
      checkOutput("abort ready", 64'(ready), 64'd1);
      checkOutput("abort tile_ready", 64'(tile_ready), 64'd0);
      return;
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("t%0d r1 ena", idx), 64'(out_ena), 64'd1);
    checkOutput($sformatf("t%0d r1 addr", idx), 64'(out_addra), 64'(vecs[idx].addr1));
    checkOutput($sformatf("t%0d r1 wea", idx), 64'(out_wea), 64'(vecs[idx].wea));
    checkOutput($sformatf("t%0d r1 din", idx), out_dina, expectedDin(vecs[idx].data, 1, vecs[idx].wea));
    if (last) tile_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput($sformatf("t%0d gap ena", idx), 64'(out_ena), 64'd0);
    checkOutput($sformatf("t%0d gap tile_ready", idx), 64'(tile_ready), last ? 64'd0 : 64'd1);
    checkOutput($sformatf("t%0d gap done", idx), 64'(done), last ? 64'd1 : 64'd0);
    if (last) begin
      checkOutput("done ready low", 64'(ready), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("post done", 64'(done), 64'd0);
      checkOutput("post done ready", 64'(ready), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] expWord;
    int          i;
    int          j;
    int          val;
    int          writesBefore;
    bit          ok;
    checks     = 0;
    failures   = 0;
    writeCount = 0;
    doneCount  = 0;
    for (int a = 0; a < 4096; a++) mem[a] = '0;

    // Tile (tr,tc) = (k/4, k%4): addresses and lane enables worked out by hand.
    vecs[0]  = '{data: '0, addr0: 12'd0, addr1: 12'd2,  wea: 8'h0F};
    vecs[1]  = '{data: '0, addr0: 12'd0, addr1: 12'd2,  wea: 8'hF0};
    vecs[2]  = '{data: '0, addr0: 12'd1, addr1: 12'd3,  wea: 8'h0F};
    vecs[3]  = '{data: '0, addr0: 12'd1, addr1: 12'd3,  wea: 8'hF0};
    vecs[4]  = '{data: '0, addr0: 12'd4, addr1: 12'd6,  wea: 8'h0F};
    vecs[5]  = '{data: '0, addr0: 12'd4, addr1: 12'd6,  wea: 8'hF0};
    vecs[6]  = '{data: '0, addr0: 12'd5, addr1: 12'd7,  wea: 8'h0F};
    vecs[7]  = '{data: '0, addr0: 12'd5, addr1: 12'd7,  wea: 8'hF0};
    vecs[8]  = '{data: '0, addr0: 12'd8, addr1: 12'd10, wea: 8'h0F};
    vecs[9]  = '{data: '0, addr0: 12'd8, addr1: 12'd10, wea: 8'hF0};
    vecs[10] = '{data: '0, addr0: 12'd9, addr1: 12'd11, wea: 8'h0F};
    vecs[11] = '{data: '0, addr0: 12'd9, addr1: 12'd11, wea: 8'hF0};
    for (int k = 0; k < 12; k++) begin
      vecs[k].data = {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
    end

    rst = 1'b1;
    clr = 1'b0;
    start = 1'b0;
    tile_valid = 1'b0;
    tile_data = '0;
    #12;
    checkOutput("reset ready", 64'(ready), 64'd1);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset tile_ready", 64'(tile_ready), 64'd0);
    checkOutput("reset ena", 64'(out_ena), 64'd0);
    checkOutput("reset wea", 64'(out_wea), 64'd0);
    checkOutput("reset addr", 64'(out_addra), 64'd0);
    checkOutput("reset din", out_dina, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Valid without start must not be accepted.
    tile_valid = 1'b1;
    tile_data  = 64'hDEAD_BEEF_CAFE_F00D;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("nostart tile_ready", 64'(tile_ready), 64'd0);
    end
    tile_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("nostart writes", 64'(writeCount), 64'd0);

    // Full matrix, tile_valid held high throughout, stray start before tile 5.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start tile_ready", 64'(tile_ready), 64'd1);
    checkOutput("start ready", 64'(ready), 64'd0);
    for (int k = 0; k < 12; k++) applyStimulus(k, k == 5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full writes", 64'(writeCount), 64'd24);
    checkOutput("full done count", 64'(doneCount), 64'd1);
    for (int a = 0; a < 12; a++) begin
      i = a / 2;
      expWord = '0;
      for (int e = 0; e < 4; e++) begin
        j = (a % 2) * 4 + e;
        val = 4 * ((i / 2) * 4 + j / 2) + (i % 2) * 2 + (j % 2) + 1;
        expWord[e*16 +: 16] = 16'(val);
      end
      checkOutput($sformatf("readback word %0d", a), mem[a], expWord);
    end

    // Abort during the first write of tile (1,2), then restart from (0,0).
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    writesBefore = writeCount;
    for (int k = 0; k < 6; k++) applyStimulus(k, 1'b0, 1'b0);
    applyStimulus(6, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort writes", 64'(writeCount - writesBefore), 64'd13);
    checkOutput("abort no done", 64'(doneCount), 64'd1);
    checkOutput("abort idle ready", 64'(ready), 64'd1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write.
    tile_data  = vecs[2].data;
    tile_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      if (tile_ready) ok = 1'b1;
    end
    checkOutput("rst test accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    tile_valid = 1'b0;
    checkOutput("pre rst ena", 64'(out_ena), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("async rst ready", 64'(ready), 64'd1);
    checkOutput("async rst tile_ready", 64'(tile_ready), 64'd0);
    checkOutput("async rst ena", 64'(out_ena), 64'd0);
    checkOutput("async rst wea", 64'(out_wea), 64'd0);
    checkOutput("async rst addr", 64'(out_addra), 64'd0);
    checkOutput("async rst din", out_dina, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after rst ready", 64'(ready), 64'd1);
    checkOutput("after rst ena", 64'(out_ena), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_tile_writer.md
Name: out_tile_writer

Overview:
- Writer side of the output result BRAM: receives BLOCK_SIZE x BLOCK_SIZE result tiles from the systolic core and stores them in the BRAM's port A. The existing host read port then reads the results back through the BRAM's other port.
- Packs each tile row into its lane of a CHUNK_SIZE-element BRAM word using byte write enables, so no strip buffer is needed.
- Result matrix C (I_OUTER_DIMENSION x W_OUTER_DIMENSION) is stored row-major, with element 0 of each word at the LSBs.

Parameters:
- WIDTH, 16, bits per element; must be a multiple of 8.
- BLOCK_SIZE, 2, systolic tile dimension.
- CHUNK_SIZE, 4, elements per BRAM word; must be a multiple of BLOCK_SIZE.
- W_OUTER_DIMENSION, 8, columns of C; must be a multiple of CHUNK_SIZE.
- I_OUTER_DIMENSION, 6, rows of C; must be a multiple of BLOCK_SIZE.
- ADDR_WIDTH, 12, width of the BRAM port A address.
- Derived values (localparams):
  - WPR = W_OUTER_DIMENSION/CHUNK_SIZE (words per row)
  - TR = I_OUTER_DIMENSION/BLOCK_SIZE (tile rows)
  - TC = W_OUTER_DIMENSION/BLOCK_SIZE (tile columns)
  - MAX_FLAG = TR*TC (total tiles)
  - NBE = WIDTH*CHUNK_SIZE/8 (byte enables per word)

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous abort, returns the block to IDLE.
- start  in  1  one-cycle pulse that begins a matrix.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse after the last tile has been written.
- tile_valid  in  1  a tile is presented on tile_data.
- tile_ready  out  1  the writer can accept a tile.
- tile_data  in  BLOCK_SIZE*BLOCK_SIZE*WIDTH  element [r][c] at bits (r*BLOCK_SIZE+c)*WIDTH +: WIDTH.
- out_ena  out  1  BRAM port A enable.
- out_wea  out  NBE  BRAM port A byte write enables.
- out_addra  out  ADDR_WIDTH  BRAM port A word address.
- out_dina  out  WIDTH*CHUNK_SIZE  BRAM port A write data.

Behaviour:
- Reset (rst high, asynchronous):
  - state is IDLE; tile_row, tile_col and row counters are 0.
  - ready=1, done=0, tile_ready=0.
  - out_ena=0, out_wea=0, out_addra=0, out_dina=0.
- All outputs are registered. Outside write cycles, out_ena, out_wea, out_addra and out_dina are held at 0.
- States:
  - IDLE: ready=1. On start, clear tile_row/tile_col and go to WAIT.
  - WAIT: tile_ready=1. When tile_valid && tile_ready at a clock edge, latch tile_data and go to WRITE with row=0.
  - WRITE: lasts BLOCK_SIZE cycles, one word per cycle, row 0..BLOCK_SIZE-1. tile_ready=0.
    - After the last row, advance tile_col. On wrap at TC-1, reset tile_col and increment tile_row.
    - If the tile just written was (TR-1, TC-1), go to DONE; otherwise go to WAIT.
  - DONE: done=1 for exactly one cycle, then IDLE. ready rises in the cycle after the done pulse.
- Write address and data for tile (tr,tc), row r:
  - out_addra = (tr*BLOCK_SIZE + r)*WPR + (tc*BLOCK_SIZE)/CHUNK_SIZE.
  - lane L = (tc*BLOCK_SIZE) % CHUNK_SIZE.
  - out_dina element L+c = tile[r][c] for c in 0..BLOCK_SIZE-1; all other elements are 0.
  - out_wea bits for bytes [L*WIDTH/8, (L+BLOCK_SIZE)*WIDTH/8) are 1; all other bits are 0.
- Timing:
  - The first write strobe appears in the cycle after the accepting edge.
  - Writes are issued on BLOCK_SIZE consecutive cycles with no gaps.
  - tile_ready reasserts in the cycle after the last strobe, giving a throughput of one tile per BLOCK_SIZE+1 cycles.
- Handshake rules:
  - tile_valid while tile_ready=0 is ignored; the producer holds the tile.
  - tile_data is sampled only at the accepting edge.
- start outside IDLE is ignored.
- clr (synchronous):
  - takes priority over start and the handshake.
  - in any state, the next state is IDLE with counters zeroed; no further writes and no done pulse.
  - a write strobe already on the outputs is dropped in the next cycle.
- rst asserted mid-WRITE forces the outputs to their reset values immediately (asynchronously).
- Tile order is fixed: row-block major, column-block minor, MAX_FLAG tiles in total.

Test Plan:
- Reset and idle:
  - Assert rst mid-run → ready=1, tile_ready=0, out_ena=0, out_wea=0 immediately.
  - Release rst, drive tile_valid=1 with no start → no handshake and no writes.
- First tile:
  - start, then tile (0,0) with elements 1,2,3,4 → two cycles after acceptance begin:
    - cycle 1: addr 0, din=64'h0000_0000_0002_0001, wea=8'h0F.
    - cycle 2: addr 2, din=64'h0000_0000_0004_0003, wea=8'h0F.
- Lane packing:
  - tile (0,1) with 5,6,7,8 → addr 0, din=64'h0006_0005_0000_0000, wea=8'hF0; then addr 2, wea=8'hF0.
  - tile (0,2) → addr 1 and 3, wea=8'h0F.
  - tile (1,0) → addr 4 and 6.
- Full matrix:
  - Stream 12 tiles back-to-back → 24 writes in total.
  - Final tile (2,3) writes addr 9 and 11 with wea=8'hF0.
  - done pulses once, one cycle after the last write; ready=1 in the following cycle.
  - A BRAM model read back matches the row-major C.
- Backpressure and stray start:
  - Hold tile_valid high through WRITE → no second acceptance until tile_ready reasserts; each tile is written exactly once.
  - start pulsed during WAIT → ignored, counters unchanged.
- Abort:
  - Assert clr during the first write cycle of tile (1,2) → next cycle out_ena=0, state IDLE, no done.
  - A new start then restarts at tile (0,0), addr 0.
